// File: rtl/eb1_dec_trig_ctl_if.sv
// Trigger controller bus: CSR access, match inputs, packet outputs and halt handshake.
interface eb1_dec_trig_ctl_if;

  // Per-trigger configuration handed to the decode and LSU compare logic
  typedef struct packed {
    logic        select;
    logic        match;
    logic        m;
    logic        execute;
    logic        load;
    logic        store;
    logic [31:0] tdata2;
  } eb1_trigger_pkt_t;

  logic                        csr_wr_en;
  logic [1:0]                  csr_wr_sel;
  logic [31:0]                 csr_wr_data;
  logic [1:0]                  csr_rd_sel;
  logic [31:0]                 csr_rd_data;
  logic                        dbg_mode;
  logic                        i0_valid_d;
  logic [3:0]                  i0_trigger_match_d;
  logic                        lsu_valid;
  logic [3:0]                  lsu_trigger_match;
  eb1_trigger_pkt_t [3:0]      trigger_pkt_any;
  logic [3:0]                  trig_hit;
  logic                        trig_brkpt_req;
  logic                        trig_halt_req;
  logic                        trig_halt_ack;

  modport master (
    output csr_wr_en, csr_wr_sel, csr_wr_data, csr_rd_sel, dbg_mode,
           i0_valid_d, i0_trigger_match_d, lsu_valid, lsu_trigger_match,
           trig_halt_ack,
    input  csr_rd_data, trigger_pkt_any, trig_hit, trig_brkpt_req, trig_halt_req
  );

  modport slave (
    input  csr_wr_en, csr_wr_sel, csr_wr_data, csr_rd_sel, dbg_mode,
           i0_valid_d, i0_trigger_match_d, lsu_valid, lsu_trigger_match,
           trig_halt_ack,
    output csr_rd_data, trigger_pkt_any, trig_hit, trig_brkpt_req, trig_halt_req
  );

endinterface

// File: rtl/eb1_dec_trig_ctl.sv
// Decode-stage debug trigger controller: trigger CSR state, match combining,
// pair chaining, sticky hits and breakpoint / debug-halt sequencing.
module eb1_dec_trig_ctl #(
  parameter int unsigned NUM_TRIG = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  eb1_dec_trig_ctl_if.slave    bus
);

  localparam int unsigned SEL_W   = 2;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned NUM_PAIR = NUM_TRIG / 2;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_PEND = 1'b1
  } state_t;

  state_t                           r_state;
  state_t                           w_state_nxt;
  logic                             r_brk;
  logic                             w_brk_nxt;

  logic [SEL_W-1:0]                 r_mtsel;
  logic [NUM_TRIG-1:0]              r_dmode;
  logic [NUM_TRIG-1:0]              r_hit;
  logic [NUM_TRIG-1:0]              r_select;
  logic [NUM_TRIG-1:0]              r_action;
  logic [NUM_TRIG-1:0]              r_match;
  logic [NUM_TRIG-1:0]              r_m;
  logic [NUM_TRIG-1:0]              r_exe;
  logic [NUM_TRIG-1:0]              r_st;
  logic [NUM_TRIG-1:0]              r_ld;
  logic [NUM_PAIR-1:0]              r_chain;
  logic [NUM_TRIG-1:0][DATA_W-1:0]  r_tdata2;

  logic                             w_locked;
  logic                             w_wr_mtsel;
  logic                             w_wr_d1;
  logic                             w_wr_d2;
  logic [NUM_TRIG-1:0]              w_raw;
  logic [NUM_TRIG-1:0]              w_fire;
  logic                             w_any_halt;
  logic                             w_any_brk;
  logic                             w_chain_rd;

  // A trigger owned by debug mode cannot be modified from normal mode
  assign w_locked   = r_dmode[r_mtsel] & ~bus.dbg_mode;
  assign w_wr_mtsel = bus.csr_wr_en & (bus.csr_wr_sel == 2'd0);
  assign w_wr_d1    = bus.csr_wr_en & (bus.csr_wr_sel == 2'd1) & ~w_locked;
  assign w_wr_d2    = bus.csr_wr_en & (bus.csr_wr_sel == 2'd2) & ~w_locked;

  // Trigger CSR state; a same-cycle mtdata1 write overrides a fire on hit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mtsel  <= '0;
      r_dmode  <= '0;
      r_hit    <= '0;
      r_select <= '0;
      r_action <= '0;
      r_match  <= '0;
      r_m      <= '0;
      r_exe    <= '0;
      r_st     <= '0;
      r_ld     <= '0;
      r_chain  <= '0;
      r_tdata2 <= '0;
    end else begin
      if (w_wr_mtsel) begin
        r_mtsel <= bus.csr_wr_data[1:0];
      end
      for (int i = 0; i < NUM_TRIG; i++) begin
        if (w_wr_d1 && (r_mtsel == SEL_W'(i))) begin
          if (bus.dbg_mode) begin
            r_dmode[i] <= bus.csr_wr_data[27];
          end
          r_hit[i]    <= bus.csr_wr_data[20];
          r_select[i] <= bus.csr_wr_data[19];
          r_action[i] <= bus.csr_wr_data[12];
          r_match[i]  <= bus.csr_wr_data[7];
          r_m[i]      <= bus.csr_wr_data[6];
          r_exe[i]    <= bus.csr_wr_data[2];
          r_st[i]     <= bus.csr_wr_data[1];
          r_ld[i]     <= bus.csr_wr_data[0];
        end else if (w_fire[i]) begin
          r_hit[i] <= 1'b1;
        end
        if (w_wr_d2 && (r_mtsel == SEL_W'(i))) begin
          r_tdata2[i] <= bus.csr_wr_data;
        end
      end
      for (int p = 0; p < NUM_PAIR; p++) begin
        if (w_wr_d1 && (r_mtsel == SEL_W'(2 * p))) begin
          r_chain[p] <= bus.csr_wr_data[11];
        end
      end
    end
  end

  // Raw matches are masked in debug mode; a chained pair fires only together
  always_comb begin
    w_raw  = ((({NUM_TRIG{bus.i0_valid_d}}) & bus.i0_trigger_match_d) |
              (({NUM_TRIG{bus.lsu_valid}})  & bus.lsu_trigger_match)) &
             {NUM_TRIG{~bus.dbg_mode}};
    w_fire = w_raw;
    for (int p = 0; p < NUM_PAIR; p++) begin
      if (r_chain[p]) begin
        w_fire[2*p]   = w_raw[2*p] & w_raw[2*p+1];
        w_fire[2*p+1] = w_raw[2*p] & w_raw[2*p+1];
      end
    end
  end

  assign w_any_halt = |(w_fire & r_action);
  assign w_any_brk  = |(w_fire & ~r_action);

  // Halt FSM state register and breakpoint pulse register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_brk   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_brk   <= w_brk_nxt;
    end
  end

  // Halt outranks breakpoint; nothing new is raised while a halt is pending
  always_comb begin
    w_state_nxt = r_state;
    w_brk_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any_halt) begin
          w_state_nxt = S_PEND;
        end else begin
          w_brk_nxt = w_any_brk;
        end
      end
      S_PEND: begin
        if (bus.trig_halt_ack) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus.trig_halt_req  = (r_state == S_PEND);
  assign bus.trig_brkpt_req = r_brk;
  assign bus.trig_hit       = r_hit;

  // Chain exists only on the even trigger of each pair
  assign w_chain_rd = r_mtsel[0] ? 1'b0 : r_chain[r_mtsel[1]];

  // CSR read mux on the trigger selected by mtsel
  always_comb begin
    bus.csr_rd_data = '0;
    case (bus.csr_rd_sel)
      2'd0: bus.csr_rd_data = {(DATA_W - SEL_W)'(0), r_mtsel};
      2'd1: bus.csr_rd_data = {4'h2, r_dmode[r_mtsel], 6'b0,
                               r_hit[r_mtsel], r_select[r_mtsel], 6'b0,
                               r_action[r_mtsel], w_chain_rd, 3'b0,
                               r_match[r_mtsel], r_m[r_mtsel], 3'b0,
                               r_exe[r_mtsel], r_st[r_mtsel], r_ld[r_mtsel]};
      2'd2: bus.csr_rd_data = r_tdata2[r_mtsel];
      default: bus.csr_rd_data = '0;
    endcase
  end

  // Packet to the compare logic; access-type enables are off in debug mode
  always_comb begin
    bus.trigger_pkt_any = '0;
    for (int i = 0; i < NUM_TRIG; i++) begin
      bus.trigger_pkt_any[i].select  = r_select[i];
      bus.trigger_pkt_any[i].match   = r_match[i];
      bus.trigger_pkt_any[i].m       = r_m[i];
      bus.trigger_pkt_any[i].execute = r_exe[i] & ~bus.dbg_mode;
      bus.trigger_pkt_any[i].load    = r_ld[i]  & ~bus.dbg_mode;
      bus.trigger_pkt_any[i].store   = r_st[i]  & ~bus.dbg_mode;
      bus.trigger_pkt_any[i].tdata2  = r_tdata2[i];
    end
  end

endmodule

// File: tb/tb_eb1_dec_trig_ctl.sv
// Bench for eb1_dec_trig_ctl: directed scenarios plus random traffic against
// a word-level model of the trigger CSRs and halt/breakpoint behaviour.
module tb_eb1_dec_trig_ctl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic chk_en = 1'b0;
  int   n_chk  = 0;
  int   n_fail = 0;

  eb1_dec_trig_ctl_if bus ();

  eb1_dec_trig_ctl #(.NUM_TRIG(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Model state: readable mtdata1/mtdata2 words per trigger
  logic [31:0] m_d1 [4];
  logic [31:0] m_d2 [4];
  logic [1:0]  m_sel;
  logic        m_pend;
  logic        m_brk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_d1[i] = 32'h2000_0000;
      m_d2[i] = 32'h0;
    end
    m_sel  = 2'd0;
    m_pend = 1'b0;
    m_brk  = 1'b0;
  endtask

  // One clock of the reference behaviour using the inputs present at the edge
  task automatic model_step();
    logic [3:0]  raw;
    logic [3:0]  fire;
    logic        any_h;
    logic        any_b;
    logic        both;
    logic [31:0] mask;
    raw = 4'b0;
    if (bus.i0_valid_d) raw = raw | bus.i0_trigger_match_d;
    if (bus.lsu_valid)  raw = raw | bus.lsu_trigger_match;
    if (bus.dbg_mode)   raw = 4'b0;
    fire = raw;
    for (int p = 0; p < 2; p++) begin
      if (m_d1[2*p][11]) begin
        both = raw[2*p] & raw[2*p+1];
        fire[2*p] = both;
        fire[2*p+1] = both;
      end
    end
    any_h = 1'b0;
    any_b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (fire[i]) begin
        if (m_d1[i][12]) any_h = 1'b1;
        else any_b = 1'b1;
        m_d1[i][20] = 1'b1;
      end
    end
    if (bus.csr_wr_en) begin
      case (bus.csr_wr_sel)
        2'd0: m_sel = bus.csr_wr_data[1:0];
        2'd1: if (!(m_d1[m_sel][27] && !bus.dbg_mode)) begin
          mask = 32'h0018_18C7;
          if (m_sel[0]) mask[11] = 1'b0;
          if (bus.dbg_mode) mask[27] = 1'b1;
          m_d1[m_sel] = (m_d1[m_sel] & ~mask) | (bus.csr_wr_data & mask);
        end
        2'd2: if (!(m_d1[m_sel][27] && !bus.dbg_mode)) m_d2[m_sel] = bus.csr_wr_data;
        default: ;
      endcase
    end
    if (m_pend) begin
      m_brk = 1'b0;
      if (bus.trig_halt_ack) m_pend = 1'b0;
    end else begin
      m_pend = any_h;
      m_brk  = !any_h && any_b;
    end
  endtask

  function automatic logic [31:0] model_rd();
    case (bus.csr_rd_sel)
      2'd0: return {30'b0, m_sel};
      2'd1: return m_d1[m_sel];
      2'd2: return m_d2[m_sel];
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [37:0] pkt_exp(input int i);
    logic nd;
    nd = ~bus.dbg_mode;
    return {m_d1[i][19], m_d1[i][7], m_d1[i][6], m_d1[i][2] & nd,
            m_d1[i][0] & nd, m_d1[i][1] & nd, m_d2[i]};
  endfunction

  function automatic logic [37:0] pkt_act(input int i);
    return {bus.trigger_pkt_any[i].select, bus.trigger_pkt_any[i].match,
            bus.trigger_pkt_any[i].m, bus.trigger_pkt_any[i].execute,
            bus.trigger_pkt_any[i].load, bus.trigger_pkt_any[i].store,
            bus.trigger_pkt_any[i].tdata2};
  endfunction

  // Compare process: DUT against the model mid-cycle while out of reset
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("hit", 64'(bus.trig_hit), 64'({m_d1[3][20], m_d1[2][20], m_d1[1][20], m_d1[0][20]}));
      check("brkpt", 64'(bus.trig_brkpt_req), 64'(m_brk));
      check("halt", 64'(bus.trig_halt_req), 64'(m_pend));
      check("rd_data", 64'(bus.csr_rd_data), 64'(model_rd()));
      for (int i = 0; i < 4; i++) begin
        check($sformatf("pkt%0d", i), 64'(pkt_act(i)), 64'(pkt_exp(i)));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    #1;
  endtask

  task automatic wr(input logic [1:0] sel, input logic [31:0] d);
    bus.csr_wr_en   = 1'b1;
    bus.csr_wr_sel  = sel;
    bus.csr_wr_data = d;
    cyc();
    bus.csr_wr_en   = 1'b0;
  endtask

  task automatic fire_i0(input logic [3:0] m);
    bus.i0_valid_d = 1'b1;
    bus.i0_trigger_match_d = m;
    cyc();
    bus.i0_valid_d = 1'b0;
    bus.i0_trigger_match_d = 4'b0;
  endtask

  initial begin
    bus.csr_wr_en = 1'b0;
    bus.csr_wr_sel = 2'd0;
    bus.csr_wr_data = 32'h0;
    bus.csr_rd_sel = 2'd1;
    bus.dbg_mode = 1'b0;
    bus.i0_valid_d = 1'b0;
    bus.i0_trigger_match_d = 4'b0;
    bus.lsu_valid = 1'b0;
    bus.lsu_trigger_match = 4'b0;
    bus.trig_halt_ack = 1'b0;
    model_reset();
    cyc();
    cyc();
    rst = 1'b0;
    chk_en = 1'b1;

    // Reset state
    check("rst_hit", 64'(bus.trig_hit), 64'h0);
    check("rst_halt", 64'(bus.trig_halt_req), 64'h0);
    check("rst_brk", 64'(bus.trig_brkpt_req), 64'h0);
    check("rst_d1_t0", 64'(bus.csr_rd_data), 64'h2000_0000);
    check("rst_pkt0", 64'(pkt_act(0)), 64'h0);
    for (int k = 1; k < 4; k++) begin
      wr(2'd0, 32'(k));
      check($sformatf("rst_d1_t%0d", k), 64'(bus.csr_rd_data), 64'h2000_0000);
      check($sformatf("rst_pkt%0d", k), 64'(pkt_act(k)), 64'h0);
    end

    // Breakpoint on trigger 1
    wr(2'd0, 32'd1);
    wr(2'd2, 32'h8000_0100);
    wr(2'd1, 32'h0000_0044);
    check("t1_d1", 64'(bus.csr_rd_data), 64'h2000_0044);
    check("t1_pkt", 64'(pkt_act(1)), {26'b0, 6'b001100, 32'h8000_0100});
    fire_i0(4'b0010);
    check("t1_hit", 64'(bus.trig_hit), 64'h2);
    check("t1_brk", 64'(bus.trig_brkpt_req), 64'h1);
    cyc();
    check("t1_brk_end", 64'(bus.trig_brkpt_req), 64'h0);
    check("t1_d1_hit", 64'(bus.csr_rd_data), 64'h2010_0044);

    // Chained halt on pair (0,1)
    wr(2'd0, 32'd0);
    wr(2'd1, 32'h0000_1804);
    wr(2'd0, 32'd1);
    wr(2'd1, 32'h0000_1004);
    fire_i0(4'b0001);
    check("chain_lo_hit", 64'(bus.trig_hit), 64'h0);
    check("chain_lo_halt", 64'(bus.trig_halt_req), 64'h0);
    fire_i0(4'b0011);
    check("chain_hit", 64'(bus.trig_hit), 64'h3);
    check("chain_halt", 64'(bus.trig_halt_req), 64'h1);
    repeat (5) cyc();
    check("halt_hold", 64'(bus.trig_halt_req), 64'h1);
    bus.trig_halt_ack = 1'b1;
    cyc();
    bus.trig_halt_ack = 1'b0;
    check("halt_ack", 64'(bus.trig_halt_req), 64'h0);

    // Same-cycle breakpoint and halt: halt wins
    wr(2'd0, 32'd0);
    wr(2'd1, 32'h0000_0004);
    wr(2'd0, 32'd1);
    wr(2'd1, 32'h0000_0004);
    wr(2'd0, 32'd2);
    wr(2'd1, 32'h0000_0004);
    wr(2'd0, 32'd3);
    wr(2'd1, 32'h0000_1004);
    fire_i0(4'b1100);
    check("prio_halt", 64'(bus.trig_halt_req), 64'h1);
    check("prio_brk", 64'(bus.trig_brkpt_req), 64'h0);
    check("prio_hit", 64'(bus.trig_hit), 64'hC);
    bus.trig_halt_ack = 1'b1;
    cyc();
    bus.trig_halt_ack = 1'b0;

    // Debug-mode ownership of trigger 3
    bus.dbg_mode = 1'b1;
    wr(2'd1, 32'h0800_1004);
    bus.i0_valid_d = 1'b1;
    bus.i0_trigger_match_d = 4'b1000;
    #1;
    check("dbg_pkt_exe", 64'(pkt_act(3) >> 34) & 64'h1, 64'h0);
    cyc();
    bus.i0_valid_d = 1'b0;
    bus.i0_trigger_match_d = 4'b0;
    check("dbg_nohit", 64'(bus.trig_hit), 64'h4);
    bus.dbg_mode = 1'b0;
    wr(2'd1, 32'h0);
    wr(2'd2, 32'hDEAD_BEEF);
    check("lock_d1", 64'(bus.csr_rd_data), 64'h2800_1004);
    bus.csr_rd_sel = 2'd2;
    #1;
    check("lock_d2", 64'(bus.csr_rd_data), 64'h0);
    bus.csr_rd_sel = 2'd1;

    // Asynchronous reset while a halt is pending
    fire_i0(4'b1000);
    check("pre_rst_halt", 64'(bus.trig_halt_req), 64'h1);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("async_rst_halt", 64'(bus.trig_halt_req), 64'h0);
    check("async_rst_hit", 64'(bus.trig_hit), 64'h0);
    check("async_rst_d1", 64'(bus.csr_rd_data), 64'h2000_0000);
    cyc();
    rst = 1'b0;
    check("async_rst_pkt3", 64'(pkt_act(3)), 64'h0);

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      bus.csr_wr_en   = ($urandom_range(0, 4) == 0);
      bus.csr_wr_sel  = 2'($urandom_range(0, 3));
      bus.csr_wr_data = $urandom;
      bus.csr_rd_sel  = 2'($urandom_range(0, 3));
      bus.dbg_mode    = ($urandom_range(0, 7) == 0);
      bus.i0_valid_d  = ($urandom_range(0, 2) == 0);
      bus.i0_trigger_match_d = 4'($urandom);
      bus.lsu_valid   = ($urandom_range(0, 3) == 0);
      bus.lsu_trigger_match = 4'($urandom);
      bus.trig_halt_ack = ($urandom_range(0, 3) == 0);
      cyc();
    end
    bus.csr_wr_en = 1'b0;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/eb1_dec_trig_ctl.md
# eb1_dec_trig_ctl

Trigger controller for the decode-stage debug trigger datapath. Holds the four triggers' mtsel/mtdata1/mtdata2 state, services CSR reads and writes with debug-mode locking, and drives `trigger_pkt_any` to the decode and LSU match logic. It combines the returned match vectors, applies pair chaining, records sticky hit bits, and sequences the resulting breakpoint-exception pulse or debug-halt request/acknowledge.

## Interface
Parameters:
- `NUM_TRIG`, 4, number of triggers; 4 is the only supported value because the packet array is `[3:0]`.

Ports:
- `clk`  in  1  core clock
- `rst`  in  1  asynchronous reset, active-high
- `csr_wr_en`  in  1  CSR write strobe
- `csr_wr_sel`  in  2  write target: 0 mtsel, 1 mtdata1, 2 mtdata2, 3 ignored
- `csr_wr_data`  in  32  write data
- `csr_rd_sel`  in  2  read target, same encoding; 3 reads 0
- `csr_rd_data`  out  32  combinational read data
- `dbg_mode`  in  1  core is in debug mode
- `i0_valid_d`  in  1  decode slot valid
- `i0_trigger_match_d`  in  4  execute match from decode trigger compare
- `lsu_valid`  in  1  LSU access valid
- `lsu_trigger_match`  in  4  load/store match from LSU compare
- `trigger_pkt_any`  out  `eb1_trigger_pkt_t` [3:0]  per-trigger configuration packet
- `trig_hit`  out  4  sticky hit bits
- `trig_brkpt_req`  out  1  one-cycle breakpoint-exception pulse
- `trig_halt_req`  out  1  debug-halt request, level
- `trig_halt_ack`  in  1  halt acknowledge

## Operation
- mtdata1 fields:
  - [31:28] type, read-only 2
  - [27] dmode
  - [20] hit
  - [19] select
  - [12] action (0 = breakpoint exception, 1 = debug halt)
  - [11] chain
  - [7] match
  - [6] m
  - [2] execute
  - [1] store
  - [0] load
  - All other bits read 0.
- chain is implemented only on triggers 0 and 2. It is write-ignored and reads 0 on triggers 1 and 3.
- mtsel write latches `csr_wr_data[1:0]`. Reads return `{30'b0, mtsel}`.
- mtdata1 and mtdata2 accesses target trigger `mtsel`.
- Debug-mode locking:
  - A write to a trigger whose dmode=1 is dropped when `dbg_mode`=0.
  - dmode is writable only when `dbg_mode`=1; otherwise the written dmode value is ignored and the bit keeps its value.
- Packet fields `select`, `match`, `m`, `tdata2` come directly from the registers.
- Packet fields `execute`, `load`, `store` are the register bits ANDed with `~dbg_mode`.
- Raw match per trigger: `raw[i] = (i0_valid_d & i0_trigger_match_d[i]) | (lsu_valid & lsu_trigger_match[i])`, ANDed with `~dbg_mode`.
- Chaining, for pairs (0,1) and (2,3): when chain of the lower trigger is set, `fire[lo] = fire[hi] = raw[lo] & raw[hi]`. Otherwise `fire[i] = raw[i]`.
- Hit bits:
  - `fire[i]` sets `hit[i]`, which stays set.
  - An mtdata1 write loads hit from `csr_wr_data[20]`.
  - When a write and a fire hit the same trigger in the same cycle, the write wins.
- Action resolution over all fired triggers: if any has action=1, a halt is requested; else if any has action=0, a breakpoint is requested. Halt has priority, so a same-cycle breakpoint is dropped.
- Halt FSM:
  - IDLE → PEND on a fire resolving to halt.
  - `trig_halt_req`=1 for as long as the FSM is in PEND.
  - PEND → IDLE on the cycle `trig_halt_ack`=1 is sampled.
  - Fires while in PEND still set hit bits but raise no new request and no breakpoint.
  - An ack seen in IDLE is ignored.
- Breakpoint: `trig_brkpt_req` is a registered single-cycle pulse. It is suppressed while the FSM is in PEND.

## Timing
- Reset values:
  - mtsel = 0, mtdata2 = 0.
  - mtdata1 reads 0x2000_0000 for every trigger.
  - `trigger_pkt_any` = all 0; `trig_hit` = 0.
  - `trig_brkpt_req` = 0, `trig_halt_req` = 0; FSM in IDLE.
- A CSR write in cycle N is visible on `csr_rd_data` and `trigger_pkt_any` in cycle N+1.
- A fire in cycle N produces, in cycle N+1:
  - `trig_hit` set
  - `trig_brkpt_req` pulse, or `trig_halt_req` rise
- Ack sampled in cycle M drops `trig_halt_req` in cycle M+1. A new fire in cycle M is ignored; a fire in cycle M+1 is accepted.
- `rst` asserted mid-PEND drops `trig_halt_req` asynchronously.
- `csr_rd_data` is combinational on `csr_rd_sel`, mtsel and register state.

## Test plan
- Reset, then read each trigger's mtdata1 → 0x2000_0000; `trigger_pkt_any` all zero.
- `dbg_mode`=0: write mtsel=1, mtdata2=0x8000_0100, mtdata1=0x0000_0044. Then `i0_valid_d`=1 with `i0_trigger_match_d`=4'b0010 → next cycle `trig_hit`=4'b0010, `trig_brkpt_req` is a one-cycle pulse, mtdata1 reads 0x2010_0044.
- Trigger 0 configured with chain and action=1, trigger 1 configured with action=1; pulse `raw` 4'b0001 → no hit; pulse 4'b0011 → hit 4'b0011 and `trig_halt_req`=1. Holding `trig_halt_ack` low 5 cycles keeps the request up; ack drops it the next cycle.
- Same-cycle fire of trigger 2 (action=0) and trigger 3 (action=1) → `trig_halt_req`=1, no `trig_brkpt_req` pulse, `trig_hit`=4'b1100.
- `dbg_mode`=1: set dmode on trigger 3. Leave debug mode and write mtdata1/mtdata2 of trigger 3 → values unchanged. With `dbg_mode`=1, a match on trigger 3 → no hit and packet execute=0.
- Assert `rst` while in PEND → `trig_halt_req` falls without waiting for a clock, and all registers return to their reset values.
